// File: rtl/mem_arbiter_if.sv
// Memory request/response bundle shared by the cache-side ports and the main-memory port.
// The cache side and the arbiter's memory side use master; the arbiter's cache side and memory use slave.
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   data_valid;
  logic                   data_ready;
  logic [DATA_BITS-1:0]   data_bits;
  logic [DATA_BITS/8-1:0] data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw, data_valid, data_bits, data_mask,
    input  req_ready, data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, data_valid, data_bits, data_mask,
    output req_ready, data_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the IC and DC caches onto one memory port; holds the grant through a
// write's data beat and routes read responses back to their owner through an in-order ID FIFO.
module mem_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int DATA_BITS       = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  ic_mem,
  mem_arbiter_if.slave  dc_mem,
  mem_arbiter_if.master mem,
  output logic          resp_err
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WDATA = 1'b1;
  localparam logic       PORT_IC = 1'b0;
  localparam logic       PORT_DC = 1'b1;

  logic [0:0]     state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0] count_q;
  logic           resp_err_q;
  logic           fifo_q [MAX_OUTSTANDING];

  logic fifo_full, fifo_empty;
  logic ic_elig, dc_elig, pref_port, pref_elig, alt_elig;
  logic grant_valid, grant_port, sel_rw, addr_hs;
  logic data_en, data_port, data_hs;
  logic push, pop, head;

  always_comb begin
    // Depth is a power of two, so the count MSB alone flags a full FIFO.
    fifo_full   = count_q[PTR_W];
    fifo_empty  = (count_q == '0);
    ic_elig     = ic_mem.req_valid & (ic_mem.req_rw | ~fifo_full);
    dc_elig     = dc_mem.req_valid & (dc_mem.req_rw | ~fifo_full);
    pref_port   = ~last_grant_q;
    pref_elig   = (pref_port == PORT_DC) ? dc_elig : ic_elig;
    alt_elig    = (pref_port == PORT_DC) ? ic_elig : dc_elig;
    grant_valid = ~reset & (state_q == S_IDLE) & (pref_elig | alt_elig);
    grant_port  = pref_elig ? pref_port : ~pref_port;
    sel_rw      = (grant_port == PORT_DC) ? dc_mem.req_rw : ic_mem.req_rw;
    addr_hs     = grant_valid & mem.req_ready;

    // The data channel opens only alongside a write address handshake or while parked in WDATA.
    data_port   = (state_q == S_WDATA) ? owner_q : grant_port;
    data_en     = ~reset & ((state_q == S_WDATA) | (addr_hs & sel_rw));
    data_hs     = mem.data_valid & mem.data_ready;

    push        = addr_hs & ~sel_rw;
    pop         = ~reset & mem.resp_valid & ~fifo_empty;
    head        = fifo_q[rd_ptr_q];

    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = addr_hs ? grant_port : last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (addr_hs & sel_rw & ~data_hs) begin
          state_d = S_WDATA;
          owner_d = grant_port;
        end
      end
      default: begin
        if (data_hs) state_d = S_IDLE;
      end
    endcase
  end

  assign mem.req_valid  = grant_valid;
  assign mem.req_addr   = (grant_port == PORT_DC) ? dc_mem.req_addr : ic_mem.req_addr;
  assign mem.req_rw     = sel_rw;
  assign mem.data_valid = data_en & ((data_port == PORT_DC) ? dc_mem.data_valid : ic_mem.data_valid);
  assign mem.data_bits  = (data_port == PORT_DC) ? dc_mem.data_bits : ic_mem.data_bits;
  assign mem.data_mask  = (data_port == PORT_DC) ? dc_mem.data_mask : ic_mem.data_mask;

  assign ic_mem.req_ready  = addr_hs & (grant_port == PORT_IC);
  assign dc_mem.req_ready  = addr_hs & (grant_port == PORT_DC);
  assign ic_mem.data_ready = data_en & (data_port == PORT_IC) & mem.data_ready;
  assign dc_mem.data_ready = data_en & (data_port == PORT_DC) & mem.data_ready;
  assign ic_mem.resp_valid = pop & (head == PORT_IC);
  assign dc_mem.resp_valid = pop & (head == PORT_DC);
  assign ic_mem.resp_data  = mem.resp_data;
  assign dc_mem.resp_data  = mem.resp_data;
  assign resp_err          = resp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_DC;
      owner_q      <= PORT_IC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (mem.resp_valid & fifo_empty) resp_err_q <= 1'b1;
    end
  end

  // Owner storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= grant_port;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected grants, data beats and responses;
// a monitor pops and compares whenever the DUT presents a handshake or response.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic reset;
  logic resp_err;

  mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) ic_if ();
  mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) dc_if ();
  mem_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mem_if ();

  mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .MAX_OUTSTANDING(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ic_mem   (ic_if),
    .dc_mem   (dc_if),
    .mem      (mem_if),
    .resp_err (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic port; logic rw; logic [AW-1:0] addr; } req_t;
  typedef struct packed { logic port; logic [DW-1:0] bits; logic [DW/8-1:0] mask; } wdat_t;
  typedef struct packed { logic port; logic [DW-1:0] data; } resp_t;

  req_t  exp_req_q [$];
  wdat_t exp_dat_q [$];
  resp_t exp_rsp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT presented an output with no expectation queued", name);
  endtask

  task automatic exp_req(input logic port, input logic rw, input logic [AW-1:0] addr);
    req_t r;
    r.port = port; r.rw = rw; r.addr = addr;
    exp_req_q.push_back(r);
  endtask

  task automatic exp_dat(input logic port, input logic [DW-1:0] bits, input logic [DW/8-1:0] mask);
    wdat_t w;
    w.port = port; w.bits = bits; w.mask = mask;
    exp_dat_q.push_back(w);
  endtask

  task automatic exp_rsp(input logic port, input logic [DW-1:0] data);
    resp_t p;
    p.port = port; p.data = data;
    exp_rsp_q.push_back(p);
  endtask

  task automatic monitor_step();
    req_t r; wdat_t w; resp_t p;
    if (mem_if.req_valid && mem_if.req_ready) begin
      if (exp_req_q.size() == 0) note_fail("unexpected_req");
      else begin
        r = exp_req_q.pop_front();
        $display("req  port=%s rw=%0d addr=%h", r.port ? "DC" : "IC", mem_if.req_rw, mem_if.req_addr);
        check("req_addr", DW'(mem_if.req_addr), DW'(r.addr));
        check("req_rw", DW'(mem_if.req_rw), DW'(r.rw));
        check("req_ready_ic", DW'(ic_if.req_ready), DW'(r.port == IC));
        check("req_ready_dc", DW'(dc_if.req_ready), DW'(r.port == DC));
      end
    end
    if (mem_if.data_valid && mem_if.data_ready) begin
      if (exp_dat_q.size() == 0) note_fail("unexpected_data");
      else begin
        w = exp_dat_q.pop_front();
        $display("data port=%s mask=%h bits=%h", w.port ? "DC" : "IC", mem_if.data_mask, mem_if.data_bits);
        check("data_bits", mem_if.data_bits, w.bits);
        check("data_mask", DW'(mem_if.data_mask), DW'(w.mask));
        check("data_ready_ic", DW'(ic_if.data_ready), DW'(w.port == IC));
        check("data_ready_dc", DW'(dc_if.data_ready), DW'(w.port == DC));
      end
    end
    if (ic_if.resp_valid || dc_if.resp_valid) begin
      if (exp_rsp_q.size() == 0) note_fail("unexpected_resp");
      else begin
        p = exp_rsp_q.pop_front();
        $display("resp port=%s data=%h", p.port ? "DC" : "IC", ic_if.resp_data);
        check("resp_valid_ic", DW'(ic_if.resp_valid), DW'(p.port == IC));
        check("resp_valid_dc", DW'(dc_if.resp_valid), DW'(p.port == DC));
        check("resp_data_ic", ic_if.resp_data, p.data);
        check("resp_data_dc", dc_if.resp_data, p.data);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ic_if.req_valid = 1'b0; ic_if.req_rw = 1'b0; ic_if.req_addr = '0;
    ic_if.data_valid = 1'b0; ic_if.data_bits = '0; ic_if.data_mask = '0;
    dc_if.req_valid = 1'b0; dc_if.req_rw = 1'b0; dc_if.req_addr = '0;
    dc_if.data_valid = 1'b0; dc_if.data_bits = '0; dc_if.data_mask = '0;
    mem_if.req_ready = 1'b1; mem_if.data_ready = 1'b1;
    mem_if.resp_valid = 1'b0; mem_if.resp_data = '0;
  endtask

  task automatic run_stimulus();
    logic gp [8];
    logic p;
    logic [DW-1:0] d;

    // Reset with every input asserted: all valid/ready outputs must stay low.
    idle_all();
    reset = 1'b1;
    ic_if.req_valid = 1'b1; dc_if.req_valid = 1'b1; ic_if.req_rw = 1'b1; dc_if.req_rw = 1'b1;
    ic_if.data_valid = 1'b1; dc_if.data_valid = 1'b1; mem_if.resp_valid = 1'b1;
    @(negedge clk);
    check("rst_mem_req_valid", DW'(mem_if.req_valid), 0);
    check("rst_ic_req_ready", DW'(ic_if.req_ready), 0);
    check("rst_dc_req_ready", DW'(dc_if.req_ready), 0);
    check("rst_mem_data_valid", DW'(mem_if.data_valid), 0);
    check("rst_ic_data_ready", DW'(ic_if.data_ready), 0);
    check("rst_ic_resp_valid", DW'(ic_if.resp_valid), 0);
    check("rst_dc_resp_valid", DW'(dc_if.resp_valid), 0);
    check("rst_resp_err", DW'(resp_err), 0);
    cyc();
    idle_all();
    reset = 1'b0;

    // Test 1: lone IC read, then its response.
    ic_if.req_valid = 1'b1; ic_if.req_addr = 28'h10;
    exp_req(IC, 1'b0, 28'h10);
    @(negedge clk);
    check("t1_ic_ready_same_cycle", DW'(ic_if.req_ready), 1);
    cyc();
    ic_if.req_valid = 1'b0;
    mem_if.resp_valid = 1'b1; mem_if.resp_data = {16{8'hA5}};
    exp_rsp(IC, {16{8'hA5}});
    cyc();
    mem_if.resp_valid = 1'b0;

    // Test 2: both ports read every cycle; last grant was IC, so DC leads the alternation.
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        ic_if.req_valid = 1'b1; ic_if.req_addr = 28'h100 + 28'(c);
        dc_if.req_valid = 1'b1; dc_if.req_addr = 28'h200 + 28'(c);
        p = (c % 2 == 0) ? DC : IC;
        gp[c] = p;
        exp_req(p, 1'b0, p ? 28'h200 + 28'(c) : 28'h100 + 28'(c));
      end else begin
        ic_if.req_valid = 1'b0; dc_if.req_valid = 1'b0;
      end
      if (c >= 1) begin
        d = DW'(32'h2000 + c - 1);
        mem_if.resp_valid = 1'b1; mem_if.resp_data = d;
        exp_rsp(gp[c-1], d);
      end else begin
        mem_if.resp_valid = 1'b0;
      end
      cyc();
    end
    mem_if.resp_valid = 1'b0;

    // Test 3: DC write stalls in WDATA for 3 cycles while an IC read waits.
    dc_if.req_valid = 1'b1; dc_if.req_rw = 1'b1; dc_if.req_addr = 28'h20;
    dc_if.data_valid = 1'b1; dc_if.data_bits = {4{32'hD0D1D2D3}}; dc_if.data_mask = 16'h000F;
    ic_if.req_valid = 1'b1; ic_if.req_rw = 1'b0; ic_if.req_addr = 28'h30;
    mem_if.data_ready = 1'b0;
    exp_req(DC, 1'b1, 28'h20);
    @(negedge clk);
    check("t3_data_valid_with_addr", DW'(mem_if.data_valid), 1);
    check("t3_mask_passthru", DW'(mem_if.data_mask), DW'(16'h000F));
    cyc();
    dc_if.req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t3_wdata_addr_blocked", DW'(mem_if.req_valid), 0);
      check("t3_wdata_ic_ready", DW'(ic_if.req_ready), 0);
      cyc();
    end
    mem_if.data_ready = 1'b1;
    exp_dat(DC, {4{32'hD0D1D2D3}}, 16'h000F);
    @(negedge clk);
    check("t3_ic_blocked_on_data_hs", DW'(ic_if.req_ready), 0);
    cyc();
    dc_if.data_valid = 1'b0; dc_if.req_rw = 1'b0;
    exp_req(IC, 1'b0, 28'h30);
    @(negedge clk);
    check("t3_ic_granted_after", DW'(ic_if.req_ready), 1);
    cyc();
    ic_if.req_valid = 1'b0;
    mem_if.resp_valid = 1'b1; mem_if.resp_data = DW'(32'h33);
    exp_rsp(IC, DW'(32'h33));
    cyc();
    mem_if.resp_valid = 1'b0;

    // Test 4: four outstanding IC reads fill the FIFO; writes still get through.
    ic_if.req_valid = 1'b1; ic_if.req_rw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ic_if.req_addr = 28'h40 + 28'(k);
      exp_req(IC, 1'b0, 28'h40 + 28'(k));
      cyc();
    end
    ic_if.req_addr = 28'h44;
    @(negedge clk);
    check("t4_ic_blocked_full", DW'(ic_if.req_ready), 0);
    check("t4_no_mem_req", DW'(mem_if.req_valid), 0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      // Second pass has IC preferred (last grant DC) but ineligible, so DC falls through.
      dc_if.req_valid = 1'b1; dc_if.req_rw = 1'b1; dc_if.req_addr = 28'h50 + 28'(k);
      dc_if.data_valid = 1'b1; dc_if.data_bits = {8{16'hB0B0 + 16'(k)}}; dc_if.data_mask = 16'hFFFF;
      exp_req(DC, 1'b1, 28'h50 + 28'(k));
      exp_dat(DC, {8{16'hB0B0 + 16'(k)}}, 16'hFFFF);
      @(negedge clk);
      check("t4_ic_still_blocked", DW'(ic_if.req_ready), 0);
      cyc();
    end
    idle_all();
    cyc();

    // Test 5: FIFO holds IC x4; exercise push+pop at count 3 and pointer wrap.
    mem_if.resp_valid = 1'b1; mem_if.resp_data = DW'(32'h51);
    exp_rsp(IC, DW'(32'h51));
    cyc();
    dc_if.req_valid = 1'b1; dc_if.req_rw = 1'b0; dc_if.req_addr = 28'h60;
    mem_if.resp_data = DW'(32'h52);
    exp_req(DC, 1'b0, 28'h60);
    exp_rsp(IC, DW'(32'h52));
    cyc();
    dc_if.req_addr = 28'h61; mem_if.resp_valid = 1'b0;
    exp_req(DC, 1'b0, 28'h61);
    cyc();
    dc_if.req_valid = 1'b0;
    ic_if.req_valid = 1'b1; ic_if.req_rw = 1'b0; ic_if.req_addr = 28'h62;
    @(negedge clk);
    check("t5_full_after_pushpop", DW'(ic_if.req_ready), 0);
    cyc();
    mem_if.resp_valid = 1'b1; mem_if.resp_data = DW'(32'h53);
    exp_rsp(IC, DW'(32'h53));
    @(negedge clk);
    check("t5_pop_no_free_slot", DW'(ic_if.req_ready), 0);
    cyc();
    mem_if.resp_data = DW'(32'h54);
    exp_rsp(IC, DW'(32'h54));
    exp_req(IC, 1'b0, 28'h62);
    @(negedge clk);
    check("t5_ic_after_pop", DW'(ic_if.req_ready), 1);
    cyc();
    ic_if.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_if.resp_data = DW'(32'h55 + k);
      exp_rsp((k == 2) ? IC : DC, DW'(32'h55 + k));
      cyc();
    end
    mem_if.resp_valid = 1'b0;

    // Test 6: response with empty FIFO, reset clears the error, IC wins the first tie.
    mem_if.resp_valid = 1'b1; mem_if.resp_data = DW'(32'h99);
    @(negedge clk);
    check("t6_no_ic_resp", DW'(ic_if.resp_valid), 0);
    check("t6_no_dc_resp", DW'(dc_if.resp_valid), 0);
    cyc();
    mem_if.resp_valid = 1'b0;
    @(negedge clk);
    check("t6_resp_err_set", DW'(resp_err), 1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ic_if.req_valid = 1'b1; ic_if.req_rw = 1'b0; ic_if.req_addr = 28'h70;
    dc_if.req_valid = 1'b1; dc_if.req_rw = 1'b0; dc_if.req_addr = 28'h71;
    exp_req(IC, 1'b0, 28'h70);
    @(negedge clk);
    check("t6_resp_err_cleared", DW'(resp_err), 0);
    check("t6_tie_goes_ic", DW'(ic_if.req_ready), 1);
    cyc();
    exp_req(DC, 1'b0, 28'h71);
    cyc();
    ic_if.req_valid = 1'b0; dc_if.req_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mem_if.resp_valid = 1'b1; mem_if.resp_data = DW'(32'hEE);
    @(negedge clk);
    check("t6_discarded_ic_resp", DW'(ic_if.resp_valid), 0);
    check("t6_discarded_dc_resp", DW'(dc_if.resp_valid), 0);
    cyc();
    mem_if.resp_valid = 1'b0;
    @(negedge clk);
    check("t6_resp_err_after_reset", DW'(resp_err), 1);
    cyc();
    cyc();

    check("leftover_req", DW'(exp_req_q.size()), 0);
    check("leftover_data", DW'(exp_dat_q.size()), 0);
    check("leftover_resp", DW'(exp_rsp_q.size()), 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    fork
      begin
        forever begin
          @(negedge clk);
          monitor_step();
        end
      end
      begin
        run_stimulus();
      end
      begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: stimulus still running at %0t, expected completion before 100000", $time);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
